// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU replacement and a built-in miss controller.
// Optional macro CACHE_PERF_CNT_EN adds hit/miss/writeback counter outputs.
module cache_nway #(
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             mem_address,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [3:0]              mem_byte_enable,
    input  logic [31:0]             mem_wdata,
    output logic [31:0]             mem_rdata,
    output logic                    mem_resp,
    output logic [31:0]             pmem_address,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [8*LINE_BYTES-1:0] pmem_wdata,
    input  logic [8*LINE_BYTES-1:0] pmem_rdata,
    input  logic                    pmem_resp
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count,
    output logic [31:0]             wb_count
`endif
);

    localparam int LW    = 8 * LINE_BYTES;
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Tag and data storage is never reset; validity alone decides whether a line is usable.
    logic [TAG_W-1:0] tag_mem  [NUM_WAYS][NUM_SETS];
    logic [LW-1:0]    data_mem [NUM_WAYS][NUM_SETS];

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_reg;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] dirty_reg;
    logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru_reg;
    logic [WAY_W-1:0]                  victim_reg;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  byte_off;
    logic [OFF_W+4:0]  word_lsb;
    logic              req;
    logic              is_write;

    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    first_inv;
    logic                any_inv;
    logic [WAY_W-1:0]    victim_sel;
    logic                victim_dirty;
    logic [LW-1:0]       hit_line;
    logic [31:0]         hit_word;
    logic [31:0]         wr_word;
    logic [TAG_W-1:0]    victim_tag;
    logic                idle_hit;
    logic                write_hit;
    logic                fill_done;

    assign req_tag  = mem_address[31 -: TAG_W];
    assign req_idx  = mem_address[OFF_W +: IDX_W];
    assign byte_off = mem_address[OFF_W-1:0];
    assign word_lsb = {byte_off >> 2, 5'b00000};
    assign req      = mem_read | mem_write;
    assign is_write = mem_write;

    // Walk the tree from the root following each node toward its less recently used half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        int node;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            node = 2 * node + 1 + int'(bits[node]);
        end
        return WAY_W'(node - (NUM_WAYS - 1));
    endfunction

    // Along the path to the touched way, point every node at the opposite half.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] res;
        logic                dir;
        int                  node;
        res  = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir       = way[WAY_W-1-l];
            res[node] = ~dir;
            node      = 2 * node + 1 + int'(dir);
        end
        return res;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign hit_vec[gi] = valid_reg[req_idx][gi] && (tag_mem[gi][req_idx] == req_tag);
        end
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word[gi*8 +: 8] = mem_byte_enable[gi] ? mem_wdata[gi*8 +: 8]
                                                            : hit_word[gi*8 +: 8];
        end
    endgenerate

    assign hit = |hit_vec;

    always_comb begin
        hit_way   = '0;
        first_inv = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid_reg[req_idx][w]) begin
                first_inv = WAY_W'(w);
            end
        end
    end

    assign any_inv      = ~&valid_reg[req_idx];
    assign victim_sel   = any_inv ? first_inv : plru_victim(plru_reg[req_idx]);
    assign victim_dirty = valid_reg[req_idx][victim_sel] & dirty_reg[req_idx][victim_sel];
    assign hit_line     = data_mem[hit_way][req_idx];
    assign hit_word     = hit_line[word_lsb +: 32];
    assign victim_tag   = tag_mem[victim_reg][req_idx];
    assign idle_hit     = (state_reg == IDLE) && req && hit;
    assign write_hit    = idle_hit && is_write;
    assign fill_done    = (state_reg == FILL) && pmem_resp;

    assign mem_rdata  = hit_word;
    assign pmem_wdata = data_mem[victim_reg][req_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req && !hit) begin
                    state_next = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {req_tag, req_idx, {OFF_W{1'b0}}};
        case (state_reg)
            IDLE: begin
                mem_resp = req && hit;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {victim_tag, req_idx, {OFF_W{1'b0}}};
            end
            FILL: begin
                pmem_read = 1'b1;
            end
            default: ;
        endcase
    end

    // Victim is frozen on leaving IDLE so writeback and fill target the same way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            dirty_reg  <= '0;
            plru_reg   <= '0;
            victim_reg <= '0;
        end else begin
            if (state_reg == IDLE) begin
                victim_reg <= victim_sel;
            end
            if (fill_done) begin
                valid_reg[req_idx][victim_reg] <= 1'b1;
                dirty_reg[req_idx][victim_reg] <= 1'b0;
            end
            if (idle_hit) begin
                plru_reg[req_idx] <= plru_touch(plru_reg[req_idx], hit_way);
                if (is_write) begin
                    dirty_reg[req_idx][hit_way] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[victim_reg][req_idx]  <= req_tag;
            data_mem[victim_reg][req_idx] <= pmem_rdata;
        end else if (write_hit) begin
            data_mem[hit_way][req_idx][word_lsb +: 32] <= wr_word;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // The completion that follows a fill is not a first-cycle hit, so it is excluded.
    logic after_miss_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count      <= '0;
            miss_count     <= '0;
            wb_count       <= '0;
            after_miss_reg <= 1'b0;
        end else begin
            if (mem_resp && !after_miss_reg) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state_reg == IDLE) && (state_next != IDLE)) begin
                miss_count <= miss_count + 32'd1;
            end
            if ((state_reg == WRITEBACK) && pmem_resp) begin
                wb_count <= wb_count + 32'd1;
            end
            if (fill_done) begin
                after_miss_reg <= 1'b1;
            end else if (state_reg == IDLE) begin
                after_miss_reg <= 1'b0;
            end
        end
    end
`endif

endmodule
